// File: rtl/logic_arb_pkg.sv
// logic_arb_pkg: shared widths and op encodings for the logic-unit arbiter.
package logic_arb_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int TAG_W_DEF = 4;

    localparam logic [3:0] LOGIC_AND = 4'd0;
    localparam logic [3:0] LOGIC_XOR = 4'd1;
    localparam logic [3:0] LOGIC_OR  = 4'd2;

endpackage : logic_arb_pkg

// File: rtl/logic_arb_alu.sv
// logic_arb_alu: combinational AND/XOR/OR datapath with illegal-op detect.
// Any op code outside AND/XOR/OR yields result 0 and illegal 1.
module logic_arb_alu
    import logic_arb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    // Decode the op and select the matching bitwise result.
    always_comb begin
        // NOTE: defaults before the case give every output a value on every path, so no latch is inferred.
        result  = '0;
        illegal = 1'b0;
        case (op)
            LOGIC_AND: result  = src1 & src2;
            LOGIC_XOR: result  = src1 ^ src2;
            LOGIC_OR:  result  = src1 | src2;
            default:   illegal = 1'b1;
        endcase
    end

endmodule : logic_arb_alu

// File: rtl/logic_arb.sv
// logic_arb: two-requester arbiter feeding one shared logic unit, with a
// single valid/ready output register.
// Build option: define LOGIC_ARB_RR_EN for round-robin arbitration; by default
// requester 0 has fixed priority.
module logic_arb
    import logic_arb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_src1,
    input  logic [XLEN-1:0]  req0_src2,
    input  logic [3:0]       req0_op,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_src1,
    input  logic [XLEN-1:0]  req1_src2,
    input  logic [3:0]       req1_op,
    input  logic [TAG_W-1:0] req1_tag,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [XLEN-1:0]  resp_result,
    output logic             resp_illegal
);

    logic            slot_free;
    logic            grant1;
    logic            accept;
    logic [XLEN-1:0] sel_src1;
    logic [XLEN-1:0] sel_src2;
    logic [3:0]      sel_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;

    // The output register can take a new result when empty or being drained.
    assign slot_free = !resp_valid || resp_ready;

`ifdef LOGIC_ARB_RR_EN
    logic last_win;

    // Round-robin: on contention the requester that did not win last goes.
    assign grant1 = req1_valid && (!req0_valid || !last_win);

    // Remember the last accepted requester; idle and stall cycles keep it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= 1'b1;
        end else if (accept) begin
            // NOTE: non-blocking assignment so every sequential block samples pre-edge values.
            last_win <= grant1;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    assign grant1 = req1_valid && !req0_valid;
`endif

    // grant1 already implies req1_valid, so ready never rises without valid.
    assign req0_ready = req0_valid && !grant1 && slot_free;
    assign req1_ready = grant1 && slot_free;
    assign accept     = req0_ready || req1_ready;

    assign sel_src1 = grant1 ? req1_src1 : req0_src1;
    assign sel_src2 = grant1 ? req1_src2 : req0_src2;
    assign sel_op   = grant1 ? req1_op   : req0_op;

    logic_arb_alu #(.XLEN(XLEN)) u_alu (
        .src1    (sel_src1),
        .src2    (sel_src2),
        .op      (sel_op),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    // Output register: load on accept, clear on a drain without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data fields are reset too, since consumers can observe resp_* with resp_valid low.
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_tag     <= '0;
            resp_result  <= '0;
            resp_illegal <= 1'b0;
        end else if (accept) begin
            resp_valid   <= 1'b1;
            resp_id      <= grant1;
            resp_tag     <= grant1 ? req1_tag : req0_tag;
            resp_result  <= alu_result;
            resp_illegal <= alu_illegal;
        end else if (resp_ready) begin
            resp_valid   <= 1'b0;
        end
    end

endmodule : logic_arb

// File: tb/tb_logic_arb.sv
// tb_logic_arb: directed bench for logic_arb. Inputs change and outputs are
// sampled 1-2 time units after the rising clock edge.
`timescale 1ns/1ps
module tb_logic_arb;
    import logic_arb_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [XLEN-1:0]  req0_src1, req0_src2, req1_src1, req1_src2;
    logic [3:0]       req0_op, req1_op;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             resp_valid, resp_ready, resp_id, resp_illegal;
    logic [TAG_W-1:0] resp_tag;
    logic [XLEN-1:0]  resp_result;

    int n_checks = 0;
    int n_errors = 0;

    logic_arb #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_src1    (req0_src1),
        .req0_src2    (req0_src2),
        .req0_op      (req0_op),
        .req0_tag     (req0_tag),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_src1    (req1_src1),
        .req1_src2    (req1_src2),
        .req1_op      (req1_op),
        .req1_tag     (req1_tag),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_tag     (resp_tag),
        .resp_result  (resp_result),
        .resp_illegal (resp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic exp_id;

        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_src1 = '0; req0_src2 = '0; req0_op = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_src1 = '0; req1_src2 = '0; req1_op = '0; req1_tag = '0;
        resp_ready = 1'b1;

        // ---- reset state ----
        #12;
        check("rst_valid",   64'(resp_valid),   64'd0);
        check("rst_id",      64'(resp_id),      64'd0);
        check("rst_tag",     64'(resp_tag),     64'd0);
        check("rst_result",  resp_result,       64'd0);
        check("rst_illegal", 64'(resp_illegal), 64'd0);
        check("rst_r0rdy",   64'(req0_ready),   64'd0);
        check("rst_r1rdy",   64'(req1_ready),   64'd0);
        rst_n = 1'b1;
        tick();

        // ---- contention from reset: OR on req0 (tag 5), XOR on req1 (tag 9) ----
        req0_valid = 1'b1; req0_op = LOGIC_OR;  req0_tag = 4'd5;
        req0_src1  = 64'h0000_0000_FFFF_FFFF; req0_src2 = 64'h0000_FFFF_0000_FFFF;
        req1_valid = 1'b1; req1_op = LOGIC_XOR; req1_tag = 4'd9;
        req1_src1  = 64'hAAAA_AAAA_AAAA_AAAA; req1_src2 = 64'hFFFF_FFFF_0000_0000;
        for (int i = 0; i < 4; i++) begin
`ifdef LOGIC_ARB_RR_EN
            exp_id = i[0];
`else
            exp_id = 1'b0;
`endif
            #1;
            check("cont_r0rdy", 64'(req0_ready), 64'(!exp_id));
            check("cont_r1rdy", 64'(req1_ready), 64'(exp_id));
            tick();
            check("cont_valid", 64'(resp_valid), 64'd1);
            check("cont_id",    64'(resp_id),    64'(exp_id));
            check("cont_tag",   64'(resp_tag),   exp_id ? 64'd9 : 64'd5);
            check("cont_result", resp_result,
                  exp_id ? 64'h5555_5555_AAAA_AAAA : 64'h0000_FFFF_FFFF_FFFF);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("drain_valid", 64'(resp_valid), 64'd0);

        // ---- single request: req0 AND, tag 3 ----
        req0_valid = 1'b1; req0_op = LOGIC_AND; req0_tag = 4'd3;
        req0_src1  = 64'hFF00_FF00_FF00_FF00; req0_src2 = 64'h0F0F_0F0F_0F0F_0F0F;
        #1;
        check("single_r0rdy", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        check("single_valid",  64'(resp_valid), 64'd1);
        check("single_result", resp_result,     64'h0F00_0F00_0F00_0F00);
        check("single_id",     64'(resp_id),    64'd0);
        check("single_tag",    64'(resp_tag),   64'd3);

        // ---- back-pressure: consumer stalls 3 cycles with req1 XOR pending ----
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = LOGIC_XOR; req1_tag = 4'd6;
        req1_src1  = 64'h0123_4567_89AB_CDEF; req1_src2 = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_r0rdy", 64'(req0_ready), 64'd0);
            check("stall_r1rdy", 64'(req1_ready), 64'd0);
            tick();
            check("stall_valid",  64'(resp_valid), 64'd1);
            check("stall_result", resp_result,     64'h0F00_0F00_0F00_0F00);
            check("stall_id",     64'(resp_id),    64'd0);
            check("stall_tag",    64'(resp_tag),   64'd3);
        end
        resp_ready = 1'b1;
        #1;
        check("release_r1rdy", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check("bp_valid",  64'(resp_valid), 64'd1);
        check("bp_result", resp_result,     64'hFEDC_BA98_7654_3210);
        check("bp_id",     64'(resp_id),    64'd1);
        check("bp_tag",    64'(resp_tag),   64'd6);

        // ---- illegal op on req1 ----
        req1_valid = 1'b1; req1_op = 4'd7; req1_tag = 4'hA;
        req1_src1  = '1; req1_src2 = '1;
        #1;
        check("ill_r1rdy", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check("ill_valid",   64'(resp_valid),   64'd1);
        check("ill_result",  resp_result,       64'd0);
        check("ill_flag",    64'(resp_illegal), 64'd1);
        check("ill_id",      64'(resp_id),      64'd1);
        check("ill_tag",     64'(resp_tag),     64'hA);
        tick();
        check("ill_drained", 64'(resp_valid), 64'd0);

        // ---- reset while stalled ----
        req0_valid = 1'b1; req0_op = LOGIC_OR; req0_tag = 4'd2;
        req0_src1  = 64'h1; req0_src2 = 64'h2;
        tick();
        req0_valid = 1'b0;
        resp_ready = 1'b0;
        check("pre_rst_valid",  64'(resp_valid), 64'd1);
        check("pre_rst_result", resp_result,     64'h3);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid",  64'(resp_valid), 64'd0);
        check("midrst_result", resp_result,     64'd0);
        check("midrst_tag",    64'(resp_tag),   64'd0);
        #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("postrst_r0rdy", 64'(req0_ready), 64'd1);
        check("postrst_r1rdy", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("postrst_id",    64'(resp_id),    64'd0);
        check("postrst_valid", 64'(resp_valid), 64'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_logic_arb
